// File: rtl/deb_frame_ctrl.sv
// Debug frame sequencer: drives the debug PISO through clear/load/shift, reassembles
// the 12-byte stream into shadow registers and commits it to the Q outputs atomically.
module deb_frame_ctrl #(
  parameter int NBYTES = 12
) (
  input  logic        CLKEXT,
  input  logic        RST_GLO,
  input  logic        START,
  input  logic        ABORT,
  input  logic        FRAME_ACK,
  input  logic [7:0]  D_IN,
  output logic        EN_PISO_DEB,
  output logic        CLR_PISO_DEB,
  output logic        SHIFT_DEB,
  output logic [15:0] SSFR_Q,
  output logic [15:0] CON_SIG_Q,
  output logic [15:0] MAC2_Q,
  output logic [15:0] MAC1_Q,
  output logic [7:0]  DD_Q,
  output logic [7:0]  DC_Q,
  output logic [7:0]  DB_Q,
  output logic [7:0]  DA_Q,
  output logic        BUSY,
  output logic        FRAME_VALID,
  output logic        OVERRUN
);

  localparam logic [3:0] LastCnt = 4'(NBYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ARM,
    ST_LOAD,
    ST_SHIFT,
    ST_LAST
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       abort_q, abort_d;
  logic       en_q, en_d;
  logic       clr_q, clr_d;
  logic       shift_q, shift_d;
  logic       busy_q, busy_d;
  logic       fv_q, ovr_q;
  logic       commit, abortHit, capture;
  logic [7:0] shadow_q [NBYTES];

  // abort_q remembers that the current CLEAR pass ends the frame rather than starting one
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    abort_d  = abort_q;
    commit   = 1'b0;
    abortHit = ABORT && (state_q != ST_IDLE);
    if (abortHit) begin
      state_d = ST_CLEAR;
      abort_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START && !ABORT) begin
            state_d = ST_CLEAR;
            abort_d = 1'b0;
          end
        end
        ST_CLEAR: begin
          state_d = abort_q ? ST_IDLE : ST_ARM;
          abort_d = 1'b0;
        end
        ST_ARM:  state_d = ST_LOAD;
        ST_LOAD: begin
          state_d = ST_SHIFT;
          cnt_d   = 4'd0;
        end
        ST_SHIFT: begin
          if (cnt_q == LastCnt) state_d = ST_LAST;
          else                  cnt_d   = cnt_q + 4'd1;
        end
        ST_LAST: begin
          state_d = ST_IDLE;
          commit  = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    capture = (state_q == ST_SHIFT) && (cnt_q != 4'd0) && !abortHit;
  end

  // Outputs are decoded from the next state so they line up with the state register
  always_comb begin
    clr_d   = (state_d == ST_CLEAR);
    en_d    = (state_d == ST_LOAD) || (state_d == ST_SHIFT) || (state_d == ST_LAST);
    shift_d = (state_d == ST_SHIFT);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLKEXT) begin
    if (RST_GLO) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      abort_q <= 1'b0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      shift_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
    end
  end

  // Byte k-1 arrives while the counter reads k; the final byte is taken in LAST
  always_ff @(posedge CLKEXT) begin
    if (RST_GLO || abortHit) begin
      for (int i = 0; i < NBYTES; i++) shadow_q[i] <= 8'h00;
    end else if (capture) begin
      shadow_q[cnt_q - 4'd1] <= D_IN;
    end else if (commit) begin
      shadow_q[NBYTES-1] <= D_IN;
    end
  end

  // The last byte bypasses the shadow so all twelve land on the same commit edge
  always_ff @(posedge CLKEXT) begin
    if (RST_GLO) begin
      SSFR_Q    <= 16'h0000;
      CON_SIG_Q <= 16'h0000;
      MAC2_Q    <= 16'h0000;
      MAC1_Q    <= 16'h0000;
      DD_Q      <= 8'h00;
      DC_Q      <= 8'h00;
      DB_Q      <= 8'h00;
      DA_Q      <= 8'h00;
    end else if (commit) begin
      SSFR_Q    <= {shadow_q[0], shadow_q[1]};
      CON_SIG_Q <= {shadow_q[2], shadow_q[3]};
      MAC2_Q    <= {shadow_q[4], shadow_q[5]};
      MAC1_Q    <= {shadow_q[6], shadow_q[7]};
      DD_Q      <= shadow_q[8];
      DC_Q      <= shadow_q[9];
      DB_Q      <= shadow_q[10];
      DA_Q      <= D_IN;
    end
  end

  always_ff @(posedge CLKEXT) begin
    if (RST_GLO) begin
      fv_q  <= 1'b0;
      ovr_q <= 1'b0;
    end else if (commit) begin
      fv_q <= 1'b1;
      if (fv_q && !FRAME_ACK) ovr_q <= 1'b1;
    end else if (FRAME_ACK) begin
      fv_q <= 1'b0;
    end
  end

  assign EN_PISO_DEB  = en_q;
  assign CLR_PISO_DEB = clr_q;
  assign SHIFT_DEB    = shift_q;
  assign BUSY         = busy_q;
  assign FRAME_VALID  = fv_q;
  assign OVERRUN      = ovr_q;

endmodule

// File: tb/tb_deb_frame_ctrl.sv
// Directed bench for deb_frame_ctrl with a behavioural debug PISO feeding D_IN.
module tb_deb_frame_ctrl;

  logic        clkExt;
  logic        rstGlo, start, abortReq, frameAck;
  logic [7:0]  dIn;
  logic        enPiso, clrPiso, shiftDeb;
  logic [15:0] ssfrQ, conSigQ, mac2Q, mac1Q;
  logic [7:0]  ddQ, dcQ, dbQ, daQ;
  logic        busy, frameValid, overrun;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] pisoBytes [12];
  logic [7:0] pisoSr [12];
  logic [7:0] pisoOut;

  deb_frame_ctrl #(.NBYTES(12)) dut (
    .CLKEXT(clkExt), .RST_GLO(rstGlo), .START(start), .ABORT(abortReq),
    .FRAME_ACK(frameAck), .D_IN(dIn),
    .EN_PISO_DEB(enPiso), .CLR_PISO_DEB(clrPiso), .SHIFT_DEB(shiftDeb),
    .SSFR_Q(ssfrQ), .CON_SIG_Q(conSigQ), .MAC2_Q(mac2Q), .MAC1_Q(mac1Q),
    .DD_Q(ddQ), .DC_Q(dcQ), .DB_Q(dbQ), .DA_Q(daQ),
    .BUSY(busy), .FRAME_VALID(frameValid), .OVERRUN(overrun)
  );

  initial clkExt = 1'b0;
  always #5 clkExt = ~clkExt;

  // PISO: load on EN without SHIFT, present the head byte on each shift edge
  always @(posedge clkExt) begin
    if (clrPiso) begin
      for (int i = 0; i < 12; i++) pisoSr[i] <= 8'h00;
      pisoOut <= 8'h00;
    end else if (enPiso && !shiftDeb) begin
      for (int i = 0; i < 12; i++) pisoSr[i] <= pisoBytes[i];
    end else if (enPiso && shiftDeb) begin
      pisoOut <= pisoSr[0];
      for (int i = 0; i < 11; i++) pisoSr[i] <= pisoSr[i+1];
      pisoSr[11] <= 8'h00;
    end
  end
  assign dIn = pisoOut;

  task automatic applyStimulus(input logic r, input logic s, input logic a, input logic k);
    rstGlo   = r;
    start    = s;
    abortReq = a;
    frameAck = k;
    @(posedge clkExt);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic loadBytes(input logic [15:0] ssfr, input logic [15:0] con, input logic [15:0] mac2,
                           input logic [15:0] mac1, input logic [7:0] dd, input logic [7:0] dc,
                           input logic [7:0] db, input logic [7:0] da);
    pisoBytes[0] = ssfr[15:8];  pisoBytes[1] = ssfr[7:0];
    pisoBytes[2] = con[15:8];   pisoBytes[3] = con[7:0];
    pisoBytes[4] = mac2[15:8];  pisoBytes[5] = mac2[7:0];
    pisoBytes[6] = mac1[15:8];  pisoBytes[7] = mac1[7:0];
    pisoBytes[8] = dd;  pisoBytes[9] = dc;  pisoBytes[10] = db;  pisoBytes[11] = da;
  endtask

  task automatic checkQ(input string tag, input logic [15:0] ssfr, input logic [15:0] con,
                        input logic [15:0] mac2, input logic [15:0] mac1, input logic [7:0] dd,
                        input logic [7:0] dc, input logic [7:0] db, input logic [7:0] da);
    checkOutput({tag, " SSFR_Q"}, ssfrQ, ssfr);
    checkOutput({tag, " CON_SIG_Q"}, conSigQ, con);
    checkOutput({tag, " MAC2_Q"}, mac2Q, mac2);
    checkOutput({tag, " MAC1_Q"}, mac1Q, mac1);
    checkOutput({tag, " DD_Q"}, 16'(ddQ), 16'(dd));
    checkOutput({tag, " DC_Q"}, 16'(dcQ), 16'(dc));
    checkOutput({tag, " DB_Q"}, 16'(dbQ), 16'(db));
    checkOutput({tag, " DA_Q"}, 16'(daQ), 16'(da));
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " BUSY"}, 16'(busy), 16'h0);
    checkOutput({tag, " FRAME_VALID"}, 16'(frameValid), 16'h0);
    checkOutput({tag, " OVERRUN"}, 16'(overrun), 16'h0);
    checkOutput({tag, " EN"}, 16'(enPiso), 16'h0);
    checkOutput({tag, " CLR"}, 16'(clrPiso), 16'h0);
    checkOutput({tag, " SHIFT"}, 16'(shiftDeb), 16'h0);
    checkQ(tag, 16'h0, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0, 8'h0, 8'h0);
  endtask

  task automatic doFrame(input logic ackAtCommit);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (15) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, ackAtCommit);
  endtask

  initial begin
    int clrCount;
    loadBytes(16'hA1B2, 16'hC3D4, 16'h1234, 16'h5678, 8'h9A, 8'hBC, 8'hDE, 8'hF0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkReset("reset");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Nominal frame: k counts edges after the one that samples START
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("nom clr k=%0d", k), 16'(clrPiso), 16'(k == 0));
      checkOutput($sformatf("nom en k=%0d", k), 16'(enPiso), 16'(k >= 2 && k <= 15));
      checkOutput($sformatf("nom shift k=%0d", k), 16'(shiftDeb), 16'(k >= 3 && k <= 14));
      checkOutput($sformatf("nom busy k=%0d", k), 16'(busy), 16'(k <= 15));
      checkOutput($sformatf("nom fv k=%0d", k), 16'(frameValid), 16'(k == 16));
      if (k == 15) checkOutput("nom ssfr before commit", ssfrQ, 16'h0000);
    end
    checkQ("nom", 16'hA1B2, 16'hC3D4, 16'h1234, 16'h5678, 8'h9A, 8'hBC, 8'hDE, 8'hF0);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("hs fv held", 16'(frameValid), 16'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("hs fv cleared", 16'(frameValid), 16'h0);
    checkOutput("hs overrun", 16'(overrun), 16'h0);
    checkQ("hs", 16'hA1B2, 16'hC3D4, 16'h1234, 16'h5678, 8'h9A, 8'hBC, 8'hDE, 8'hF0);

    doFrame(1'b0);
    checkOutput("ovr first fv", 16'(frameValid), 16'h1);
    checkOutput("ovr first overrun", 16'(overrun), 16'h0);
    loadBytes(16'hA1B2, 16'hC3D4, 16'h1234, 16'h0F0F, 8'h9A, 8'hBC, 8'hDE, 8'hF0);
    doFrame(1'b0);
    checkOutput("ovr mac1", mac1Q, 16'h0F0F);
    checkOutput("ovr ssfr", ssfrQ, 16'hA1B2);
    checkOutput("ovr fv", 16'(frameValid), 16'h1);
    checkOutput("ovr overrun", 16'(overrun), 16'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ovr sticky", 16'(overrun), 16'h1);
    checkOutput("ovr ack fv", 16'(frameValid), 16'h0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkReset("reset2");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    loadBytes(16'hA1B2, 16'hC3D4, 16'h1234, 16'h5678, 8'h9A, 8'hBC, 8'hDE, 8'hF0);
    doFrame(1'b0);
    loadBytes(16'hA1B2, 16'hC3D4, 16'h1234, 16'h0F0F, 8'h9A, 8'hBC, 8'hDE, 8'hF0);
    doFrame(1'b1);
    checkOutput("coack mac1", mac1Q, 16'h0F0F);
    checkOutput("coack fv", 16'(frameValid), 16'h1);
    checkOutput("coack overrun", 16'(overrun), 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("coack ack fv", 16'(frameValid), 16'h0);

    // Abort at cnt=5: edge t samples START, cnt=5 is visible after edge t+8
    loadBytes(16'hA1B2, 16'hC3D4, 16'h1234, 16'h5678, 8'h9A, 8'hBC, 8'hDE, 8'hF0);
    doFrame(1'b0);
    loadBytes(16'h1111, 16'h2222, 16'h3333, 16'h4444, 8'h55, 8'h66, 8'h77, 8'h88);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("abt pre shift", 16'(shiftDeb), 16'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("abt clr", 16'(clrPiso), 16'h1);
    checkOutput("abt busy", 16'(busy), 16'h1);
    checkOutput("abt en", 16'(enPiso), 16'h0);
    checkOutput("abt shift", 16'(shiftDeb), 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("abt idle busy", 16'(busy), 16'h0);
    checkOutput("abt idle clr", 16'(clrPiso), 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("abt stays idle", 16'(busy), 16'h0);
    checkOutput("abt no load", 16'(enPiso), 16'h0);
    checkOutput("abt fv", 16'(frameValid), 16'h1);
    checkOutput("abt overrun", 16'(overrun), 16'h0);
    checkQ("abt", 16'hA1B2, 16'hC3D4, 16'h1234, 16'h5678, 8'h9A, 8'hBC, 8'hDE, 8'hF0);

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("abt+start busy", 16'(busy), 16'h0);
    checkOutput("abt+start clr", 16'(clrPiso), 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("abt idle noop", 16'(busy), 16'h0);
    checkOutput("abt idle fv", 16'(frameValid), 16'h1);

    // START held high across a whole frame
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("hold pre ack", 16'(frameValid), 16'h0);
    loadBytes(16'hA1B2, 16'hC3D4, 16'h1234, 16'h5678, 8'h9A, 8'hBC, 8'hDE, 8'hF0);
    clrCount = 0;
    for (int k = 0; k <= 16; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      if (clrPiso) clrCount++;
      checkOutput($sformatf("hold busy k=%0d", k), 16'(busy), 16'(k <= 15));
    end
    checkOutput("hold clr pulses", 16'(clrCount), 16'd1);
    checkOutput("hold fv", 16'(frameValid), 16'h1);
    checkQ("hold", 16'hA1B2, 16'hC3D4, 16'h1234, 16'h5678, 8'h9A, 8'hBC, 8'hDE, 8'hF0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("hold restart clr", 16'(clrPiso), 16'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("hold abort busy", 16'(busy), 16'h0);
    checkOutput("hold overrun", 16'(overrun), 16'h0);

    // Reset at cnt=7: visible after edge t+10, reset sampled at edge t+11
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst pre shift", 16'(shiftDeb), 16'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkReset("rst mid");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("rst quiet busy %0d", k), 16'(busy), 16'h0);
      checkOutput($sformatf("rst quiet fv %0d", k), 16'(frameValid), 16'h0);
    end
    loadBytes(16'hA1B2, 16'hC3D4, 16'h1234, 16'h5678, 8'h9A, 8'hBC, 8'hDE, 8'hF0);
    doFrame(1'b0);
    checkOutput("rst clean fv", 16'(frameValid), 16'h1);
    checkOutput("rst clean overrun", 16'(overrun), 16'h0);
    checkQ("rst clean", 16'hA1B2, 16'hC3D4, 16'h1234, 16'h5678, 8'h9A, 8'hBC, 8'hDE, 8'hF0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
